// File: rtl/pl_button_debouncer.sv
// Button/switch debouncer: polarity fix, 2-flop synchronizer, shared sample-tick prescaler,
// per-channel stability counter, and single-cycle press/release events.
module pl_button_debouncer #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned TICK_DIV     = 4000,
  parameter int unsigned STABLE_TICKS = 500,
  parameter bit          ACTIVE_LOW   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_state,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release,
  output logic             tick
);

  localparam int unsigned PresW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CntW  = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(TICK_DIV - 1);
  localparam logic [CntW-1:0]  CntMax  = CntW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] btn_cond;
  logic [WIDTH-1:0] sync1_q, sync2_q;

  logic [PresW-1:0] pres_q, pres_d;

  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] release_q, release_d;

  assign btn_cond = ACTIVE_LOW ? ~btn_in : btn_in;

  // Synchronizer keeps running while disabled so the level is fresh on re-enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_cond;
      sync2_q <= sync1_q;
    end
  end

  assign tick = enable & (pres_q == PresMax);

  always_comb begin
    pres_d = pres_q;
    if (!enable || tick) begin
      pres_d = '0;
    end else begin
      pres_d = pres_q + PresW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!enable) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (sync2_q[i] == state_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntMax) begin
          // Commit: event pulse is registered alongside the new level.
          cnt_d[i]     = '0;
          state_d[i]   = sync2_q[i];
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pres_q    <= '0;
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      pres_q    <= pres_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_state   = state_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_pl_button_debouncer.sv
// Bench for pl_button_debouncer: a hand-derived vector table, directed corner sequences and
// random stimulus, with an ACTIVE_LOW=1 instance alongside the default one.
module tb_pl_button_debouncer;

  localparam int unsigned W  = 8;
  localparam int unsigned TD = 4;
  localparam int unsigned ST = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         enable;
  logic [W-1:0] btn_a, btn_b;
  logic [W-1:0] st_a, pr_a, rl_a, st_b, pr_b, rl_b;
  logic         tk_a, tk_b;

  pl_button_debouncer #(
    .WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST), .ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .btn_in(btn_a),
    .btn_state(st_a), .btn_press(pr_a), .btn_release(rl_a), .tick(tk_a)
  );

  pl_button_debouncer #(
    .WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST), .ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .btn_in(btn_b),
    .btn_state(st_b), .btn_press(pr_b), .btn_release(rl_b), .tick(tk_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: index 0 is the active-high instance, 1 the active-low one.
  // A channel commits once its last ST tick samples all disagree with the accepted level.
  logic [W-1:0] m_s1 [2], m_s2 [2], m_state [2], m_press [2], m_rel [2];
  int unsigned  m_hist [2][W];
  int           m_nh [2][W];
  int           m_ph = 0;

  function automatic bit stable_new(input int k, input int ch);
    if (m_nh[k][ch] < int'(ST)) return 1'b0;
    for (int j = 0; j < int'(ST); j++) begin
      if (m_hist[k][ch][j] == m_state[k][ch]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step();
    logic [W-1:0] cond [2];
    bit           tk;
    cond[0] = btn_a;
    cond[1] = ~btn_b;
    tk = enable && (m_ph == int'(TD) - 1);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_s1[k] = '0; m_s2[k] = '0; m_state[k] = '0; m_press[k] = '0; m_rel[k] = '0;
        for (int ch = 0; ch < int'(W); ch++) begin
          m_hist[k][ch] = 0;
          m_nh[k][ch]   = 0;
        end
      end else begin
        m_press[k] = '0;
        m_rel[k]   = '0;
        for (int ch = 0; ch < int'(W); ch++) begin
          if (tk) begin
            m_hist[k][ch] = (m_hist[k][ch] << 1) | 32'(m_s2[k][ch]);
            if (m_nh[k][ch] < 32) m_nh[k][ch]++;
            if (stable_new(k, ch)) begin
              m_state[k][ch] = ~m_state[k][ch];
              if (m_state[k][ch]) m_press[k][ch] = 1'b1;
              else m_rel[k][ch] = 1'b1;
              m_nh[k][ch] = 0;
            end
          end
          if (!enable) m_nh[k][ch] = 0;
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = cond[k];
      end
    end
    m_ph = (reset || !enable) ? 0 : (m_ph + 1) % int'(TD);
  endtask

  // One clock: advance the model with the current inputs, then compare just after the edge.
  task automatic cycle();
    logic exp_tk;
    model_step();
    @(posedge clk);
    #1;
    exp_tk = enable && (m_ph == int'(TD) - 1);
    chk("state_a",   32'(st_a), 32'(m_state[0]));
    chk("press_a",   32'(pr_a), 32'(m_press[0]));
    chk("release_a", 32'(rl_a), 32'(m_rel[0]));
    chk("tick_a",    32'(tk_a), 32'(exp_tk));
    chk("state_b",   32'(st_b), 32'(m_state[1]));
    chk("press_b",   32'(pr_b), 32'(m_press[1]));
    chk("release_b", 32'(rl_b), 32'(m_rel[1]));
    chk("tick_b",    32'(tk_b), 32'(exp_tk));
  endtask

  typedef struct {
    logic         rst;
    logic [W-1:0] bin;
    logic [W-1:0] st;
    logic [W-1:0] pr;
    logic [W-1:0] rl;
    logic         tk;
  } vec_t;

  vec_t vecs [25];

  initial begin
    int          n;
    int unsigned r;
    int unsigned idx;

    // Reset for 5 cycles, ticks after rows 7,11,..; btn_in[0] rises at row 9, commits at row 20.
    for (int i = 0; i < 25; i++) begin
      vecs[i].rst = (i < 5);
      vecs[i].bin = (i >= 9) ? 8'h01 : 8'h00;
      vecs[i].st  = (i >= 20) ? 8'h01 : 8'h00;
      vecs[i].pr  = (i == 20) ? 8'h01 : 8'h00;
      vecs[i].rl  = 8'h00;
      vecs[i].tk  = 1'b0;
    end
    vecs[7].tk  = 1'b1;
    vecs[11].tk = 1'b1;
    vecs[15].tk = 1'b1;
    vecs[19].tk = 1'b1;
    vecs[23].tk = 1'b1;

    reset  = 1'b1;
    enable = 1'b1;
    btn_a  = '0;
    btn_b  = '1;

    for (int i = 0; i < 25; i++) begin
      reset = vecs[i].rst;
      btn_a = vecs[i].bin;
      cycle();
      chk("vec_state",   32'(st_a), 32'(vecs[i].st));
      chk("vec_press",   32'(pr_a), 32'(vecs[i].pr));
      chk("vec_release", 32'(rl_a), 32'(vecs[i].rl));
      chk("vec_tick",    32'(tk_a), 32'(vecs[i].tk));
    end
    chk("al_idle_state", 32'(st_b), 32'h0);

    // Glitch: bit 1 seen on two ticks only, then a 3-cycle bounce.
    n = 0;
    while (!(m_ph == int'(TD) - 1) && n < 8) begin cycle(); n++; end
    btn_a[1] = 1'b1;
    repeat (10) cycle();
    btn_a[1] = 1'b0;
    repeat (20) cycle();
    chk("glitch_no_commit", 32'(st_a[1]), 32'h0);
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) btn_a[1] = ~btn_a[1];
      cycle();
      chk("bounce_no_press", 32'(pr_a[1]), 32'h0);
    end
    btn_a[1] = 1'b0;
    repeat (20) cycle();
    chk("bounce_no_commit", 32'(st_a[1]), 32'h0);

    // Simultaneous release of bits 0 and 7.
    btn_a[7] = 1'b1;
    repeat (20) cycle();
    chk("both_high", 32'(st_a), 32'h81);
    btn_a = '0;
    n = 0;
    do begin cycle(); n++; end while (rl_a == '0 && n < 20);
    chk("release_both", 32'(rl_a), 32'h81);
    chk("release_state", 32'(st_a), 32'h00);
    cycle();
    chk("release_one_cycle", 32'(rl_a), 32'h00);

    // Enable dropped after two ticks of a pending press on bit 2.
    n = 0;
    while (!(m_ph == int'(TD) - 1) && n < 8) begin cycle(); n++; end
    btn_a[2] = 1'b1;
    repeat (9) cycle();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("disabled_no_tick", 32'(tk_a), 32'h0);
    end
    chk("disabled_hold", 32'(st_a[2]), 32'h0);
    enable = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!pr_a[2] && n < 40);
    chk("reenable_latency", 32'(n), 32'd12);

    // Reset while bit 2 is held and accepted.
    reset = 1'b1;
    cycle();
    chk("reset_state", 32'(st_a), 32'h0);
    chk("reset_no_release", 32'(rl_a), 32'h0);
    repeat (2) cycle();
    reset = 1'b0;
    n = 0;
    do begin cycle(); n++; end while (!pr_a[2] && n < 40);
    chk("post_reset_latency", 32'(n), 32'd12);

    // Active-low instance: bit 3 pulled low.
    btn_b[3] = 1'b0;
    n = 0;
    do begin cycle(); n++; end while (pr_b == '0 && n < 40);
    chk("al_press", 32'(pr_b), 32'h08);
    chk("al_state", 32'(st_b), 32'h08);

    // Random traffic on both instances with occasional enable toggles and resets.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      reset = (r < 3);
      if (r >= 3 && r < 8) enable = ~enable;
      if ($urandom_range(0, 9) == 0) begin
        idx = $urandom_range(0, W - 1);
        btn_a[idx] = ~btn_a[idx];
      end
      if ($urandom_range(0, 9) == 0) begin
        idx = $urandom_range(0, W - 1);
        btn_b[idx] = ~btn_b[idx];
      end
      cycle();
    end
    reset  = 1'b0;
    enable = 1'b1;
    repeat (20) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pl_button_debouncer.md
Name: pl_button_debouncer

Overview:
- Input-side counterpart to the PL LED drivers: conditions raw, asynchronous board push-buttons/DIP switches into clean, synchronous levels and single-cycle press/release events.
- Sits beside the LED counter logic in the PL fabric, clocked from the sysclock wizard output.
- Held idle until the wizard reports lock.

Parameters:
- WIDTH, 8: number of independent input channels.
- TICK_DIV, 4000: clk cycles per sample tick (400 MHz gives a 10 us tick). Must be >= 2.
- STABLE_TICKS, 500: consecutive ticks a new level must persist before acceptance (5 ms at default). Must be >= 1.
- ACTIVE_LOW, 0: when 1, btn_in is inverted at entry. All outputs are always active-high logical "pressed".

Ports:
- clk  input  1  block clock; all logic on posedge clk.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  run enable; tied to clock-wizard locked at top level.
- btn_in  input  WIDTH  raw asynchronous button/switch pins.
- btn_state  output  WIDTH  debounced level per channel.
- btn_press  output  WIDTH  one-cycle pulse when btn_state[i] goes 0->1.
- btn_release  output  WIDTH  one-cycle pulse when btn_state[i] goes 1->0.
- tick  output  1  sample-tick strobe, exported for debug and bench alignment.

Behaviour:
- Reset (synchronous, on any clk edge with reset=1):
  - prescaler, all channel counters, btn_state, btn_press, btn_release and tick go to 0.
  - Synchronizer flops load the inactive level: 0 after polarity correction.
- Input path: optional inversion (ACTIVE_LOW), then a 2-flop synchronizer per bit; sync[i] is the second-flop output. This adds 2 cycles of latency.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for exactly the one cycle where the count equals TICK_DIV-1; the first tick after reset release comes TICK_DIV cycles later.
  - Width is clog2(TICK_DIV).
- Channel counter cnt[i] (width clog2(STABLE_TICKS+1)) updates only on tick cycles:
  - sync[i]==btn_state[i]: cnt<=0.
  - else if cnt==STABLE_TICKS-1: btn_state[i]<=sync[i], cnt<=0 (commit).
  - else: cnt<=cnt+1.
  - On non-tick cycles, cnt and btn_state hold.
- Debounce rule: a new level must be sampled on STABLE_TICKS consecutive ticks. Any tick that samples the old level restarts the count, so glitches shorter than that never commit.
- Event pulses:
  - Registered at the same edge as the commit, so btn_press[i]/btn_release[i] are high in exactly the first cycle btn_state[i] shows its new value. Zero extra latency.
  - Forced 0 on all other cycles, including every non-tick cycle.
  - press and release are mutually exclusive per channel.
- Latency, input edge to btn_state edge: 2 sync cycles, plus wait to the next tick (0..TICK_DIV-1 cycles), plus (STABLE_TICKS-1)*TICK_DIV cycles, plus 1.
- Channels are fully independent. Simultaneous commits on several bits pulse in the same cycle.
- enable=0:
  - prescaler and all cnt held at 0; tick=0; press/release=0.
  - btn_state holds its value; synchronizer keeps running.
  - On enable rising, the prescaler restarts at 0.
- Reset mid-debounce: the partial count is discarded and btn_state goes to 0. A button still held after reset release produces a fresh press after a full debounce. No release pulse is produced by reset.
- Overflow: cnt never exceeds STABLE_TICKS-1. The prescaler wraps silently.

Test Plan:
(Bench parameters: WIDTH=8, TICK_DIV=4, STABLE_TICKS=3, ACTIVE_LOW=0 unless noted.)
1. Reset and idle: hold reset 5 cycles, btn_in=0, release reset -> all outputs 0; tick pulses at cycles 4, 8, 12... after release, width 1.
2. Clean press: btn_in[0]=1 held from 1 cycle after a tick -> btn_state[0] rises on the 3rd tick that samples sync=1 (~11 cycles after the input edge); btn_press[0] high exactly that cycle; btn_release stays 0.
3. Glitch rejection: btn_in[1] high across 2 ticks, then low before the 3rd -> btn_state[1] stays 0, no pulses. Then bounce 1/0 every 3 cycles for 40 cycles -> still no commit.
4. Release plus simultaneous events:
   - With bits 0 and 7 debounced high, drop both in the same cycle -> both btn_state bits fall in the same cycle; btn_release=8'h81 for one cycle.
   - Other bits unchanged.
5. Enable and reset mid-operation:
   - Drop enable after 2 ticks of a pending press -> no tick, btn_state holds 0. Re-enable -> 3 fresh ticks needed before press.
   - Assert reset with btn_state[2]=1 and the input still held -> btn_state=0 and no release pulse. After reset release, press[2] fires after a full debounce.
6. ACTIVE_LOW=1: btn_in=8'hFF through reset -> no press events. Drive btn_in[3]=0 held -> btn_state[3]=1 with btn_press[3] pulse after debounce.
